// File: rtl/debounce_multi.sv
// debounce_multi: N-channel push-button conditioner.
// Each channel synchronises its raw pin, debounces it into a clean level and
// classifies it into press / release / long-press pulses. Channels share no state.
// Optional auto-repeat in the long-press state: define DEBOUNCE_REPEAT_EN.
// Without it, repeat_pulse is tied low and all other behaviour is unchanged.
//
// Hold FSM (per channel):
//   state   | meaning
//   IDLE    | button released (debounced level 0)
//   HELD    | pressed, timing toward long press
//   LONG    | long press reported; waits for release (auto-repeats if enabled)

module debounce_multi #(
    parameter int N             = 4,
    parameter int CLK_HZ        = 100000000,
    parameter int DEBOUNCE_MS   = 10,
    parameter int LONG_MS       = 1000,
    parameter int REPEAT_MS     = 200,
    parameter bit IN_ACTIVE_LOW = 1'b0
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic [N-1:0] btn_in,
    output logic [N-1:0] btn_level,
    output logic [N-1:0] press_pulse,
    output logic [N-1:0] release_pulse,
    output logic [N-1:0] long_pulse,
    output logic [N-1:0] repeat_pulse
);

    localparam int DB_CYC   = CLK_HZ / 1000 * DEBOUNCE_MS;
    localparam int LONG_CYC = CLK_HZ / 1000 * LONG_MS;
    localparam int DB_W     = $clog2(DB_CYC + 1);
    localparam int HOLD_W   = $clog2(LONG_CYC + 1);

    localparam logic [DB_W-1:0]   DB_LAST   = DB_W'(DB_CYC - 1);
    localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(LONG_CYC - 1);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_HELD = 2'd1;
    localparam logic [1:0] ST_LONG = 2'd2;

    for (genvar i = 0; i < N; i++) begin : g_ch
        logic [1:0]        sync_q;
        logic              s;
        logic [DB_W-1:0]   db_cnt;
        logic              level_q;
        logic              db_fire;
        logic              rise;
        logic              fall;
        logic              press_q;
        logic              release_q;
        logic [1:0]        state;
        logic [HOLD_W-1:0] hold_cnt;
        logic              long_fire;
        logic              long_q;
        logic              rep_q;

        // Two-flop synchroniser; resets to the idle pin value so reset reads as "not pressed".
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                sync_q <= {2{IN_ACTIVE_LOW}};
            end else begin
                sync_q <= {sync_q[0], btn_in[i]};
            end
        end

        assign s       = sync_q[1] ^ IN_ACTIVE_LOW;
        assign db_fire = (s != level_q) && (db_cnt == DB_LAST);
        assign rise    = db_fire && s;
        assign fall    = db_fire && !s;

        // Debounce window: any cycle agreeing with the current level restarts it.
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                db_cnt    <= '0;
                level_q   <= 1'b0;
                press_q   <= 1'b0;
                release_q <= 1'b0;
            end else begin
                press_q   <= rise;
                release_q <= fall;
                if (s == level_q) begin
                    db_cnt <= '0;
                end else if (db_fire) begin
                    db_cnt  <= '0;
                    level_q <= s;
                end else begin
                    db_cnt <= db_cnt + 1'b1;
                end
            end
        end

        // Release has priority over a long press landing in the same cycle.
        assign long_fire = (state == ST_HELD) && (hold_cnt == HOLD_LAST) && !fall;

        // Hold FSM and hold timer; the timer freezes once LONG is reached.
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                state    <= ST_IDLE;
                hold_cnt <= '0;
                long_q   <= 1'b0;
            end else begin
                long_q <= long_fire;
                case (state)
                    ST_IDLE: begin
                        hold_cnt <= '0;
                        if (rise) begin
                            state <= ST_HELD;
                        end
                    end
                    ST_HELD: begin
                        if (fall) begin
                            state    <= ST_IDLE;
                            hold_cnt <= '0;
                        end else if (hold_cnt == HOLD_LAST) begin
                            state <= ST_LONG;
                        end else begin
                            hold_cnt <= hold_cnt + 1'b1;
                        end
                    end
                    ST_LONG: begin
                        if (fall) begin
                            state    <= ST_IDLE;
                            hold_cnt <= '0;
                        end
                    end
                    default: begin
                        state    <= ST_IDLE;
                        hold_cnt <= '0;
                    end
                endcase
            end
        end

`ifdef DEBOUNCE_REPEAT_EN
        localparam int REP_CYC = CLK_HZ / 1000 * REPEAT_MS;
        localparam int REP_W   = $clog2(REP_CYC + 1);
        localparam logic [REP_W-1:0] REP_LAST = REP_W'(REP_CYC - 1);

        logic [REP_W-1:0] rep_cnt;
        logic             rep_fire;

        assign rep_fire = (state == ST_LONG) && (rep_cnt == '0) && !fall;

        // Repeat down-counter: loaded on the long press, reloaded on every repeat.
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                rep_cnt <= '0;
                rep_q   <= 1'b0;
            end else begin
                rep_q <= rep_fire;
                if (long_fire) begin
                    rep_cnt <= REP_LAST;
                end else if (state == ST_LONG) begin
                    rep_cnt <= (rep_cnt == '0) ? REP_LAST : rep_cnt - 1'b1;
                end
            end
        end
`else
        assign rep_q = 1'b0;
`endif

        assign btn_level[i]     = level_q;
        assign press_pulse[i]   = press_q;
        assign release_pulse[i] = release_q;
        assign long_pulse[i]    = long_q;
        assign repeat_pulse[i]  = rep_q;
    end

endmodule

// File: tb/tb_debounce_multi.sv
// Directed bench for debounce_multi: DB_CYC=10, LONG_CYC=50, REP_CYC=20.
// Inputs change 1 time unit after a rising edge; outputs are sampled there too.
module tb_debounce_multi;

    localparam int N = 4;

    logic         clk = 1'b0;
    logic         rst_n;
    logic [N-1:0] btn_in;
    logic [N-1:0] btn_level, press_pulse, release_pulse, long_pulse, repeat_pulse;
    logic [0:0]   al_in, al_level, al_press, al_release, al_long, al_repeat;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    debounce_multi #(
        .N(4), .CLK_HZ(10000), .DEBOUNCE_MS(1), .LONG_MS(5), .REPEAT_MS(2), .IN_ACTIVE_LOW(1'b0)
    ) dut (
        .clk(clk), .rst_n(rst_n), .btn_in(btn_in), .btn_level(btn_level),
        .press_pulse(press_pulse), .release_pulse(release_pulse),
        .long_pulse(long_pulse), .repeat_pulse(repeat_pulse)
    );

    debounce_multi #(
        .N(1), .CLK_HZ(10000), .DEBOUNCE_MS(1), .LONG_MS(5), .REPEAT_MS(2), .IN_ACTIVE_LOW(1'b1)
    ) dut_al (
        .clk(clk), .rst_n(rst_n), .btn_in(al_in), .btn_level(al_level),
        .press_pulse(al_press), .release_pulse(al_release),
        .long_pulse(al_long), .repeat_pulse(al_repeat)
    );

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n  = 1'b0;
        btn_in = '0;
        al_in  = 1'b1;
        tick(3);
        n_cmp++;
        if ({btn_level, press_pulse, release_pulse, long_pulse, repeat_pulse} !== 20'h0) begin
            n_err++;
            $display("FAIL reset_outputs: got %h expected 0",
                     {btn_level, press_pulse, release_pulse, long_pulse, repeat_pulse});
        end
        rst_n = 1'b1;
        tick(20);
        n_cmp++;
        if ({btn_level, press_pulse, release_pulse, long_pulse, repeat_pulse} !== 20'h0) begin
            n_err++;
            $display("FAIL idle_after_reset: got %h expected 0",
                     {btn_level, press_pulse, release_pulse, long_pulse, repeat_pulse});
        end
        n_cmp++;
        if ({al_level, al_press, al_release, al_long, al_repeat} !== 5'h0) begin
            n_err++;
            $display("FAIL al_idle_after_reset: got %b expected 0",
                     {al_level, al_press, al_release, al_long, al_repeat});
        end
    endtask

    task automatic test_clean_press();
        btn_in[0] = 1'b1;
        tick(11);
        n_cmp++;
        if ({btn_level, press_pulse} !== 8'h00) begin
            n_err++;
            $display("FAIL press_early: got %h expected 00", {btn_level, press_pulse});
        end
        tick(1);
        n_cmp++;
        if ({btn_level, press_pulse} !== 8'h11) begin
            n_err++;
            $display("FAIL press_at_12: got %h expected 11", {btn_level, press_pulse});
        end
        tick(1);
        n_cmp++;
        if ({btn_level, press_pulse} !== 8'h10) begin
            n_err++;
            $display("FAIL press_single_cycle: got %h expected 10", {btn_level, press_pulse});
        end
        btn_in[0] = 1'b0;
        tick(11);
        n_cmp++;
        if ({btn_level, release_pulse} !== 8'h10) begin
            n_err++;
            $display("FAIL release_early: got %h expected 10", {btn_level, release_pulse});
        end
        tick(1);
        n_cmp++;
        if ({btn_level, release_pulse} !== 8'h01) begin
            n_err++;
            $display("FAIL release_at_12: got %h expected 01", {btn_level, release_pulse});
        end
        tick(1);
        n_cmp++;
        if (release_pulse !== 4'h0) begin
            n_err++;
            $display("FAIL release_single_cycle: got %h expected 0", release_pulse);
        end
        tick(5);
    endtask

    task automatic test_bounce();
        int presses = 0;
        int first = -1;
        for (int c = 0; c < 50; c++) begin
            if (c <= 30 && (c % 3) == 0) btn_in[1] = ((c / 3) % 2) == 0;
            tick(1);
            if (press_pulse[1]) begin
                presses++;
                if (first < 0) first = c + 1;
            end
        end
        n_cmp++;
        if (presses !== 1) begin
            n_err++;
            $display("FAIL bounce_press_count: got %0d expected 1", presses);
        end
        n_cmp++;
        if (first !== 42) begin
            n_err++;
            $display("FAIL bounce_press_time: got %0d expected 42", first);
        end
        n_cmp++;
        if (btn_level !== 4'b0010) begin
            n_err++;
            $display("FAIL bounce_level: got %b expected 0010", btn_level);
        end
        btn_in[1] = 1'b0;
        tick(14);
        n_cmp++;
        if (btn_level !== 4'b0000) begin
            n_err++;
            $display("FAIL bounce_released: got %b expected 0000", btn_level);
        end
    endtask

    task automatic test_long_hold();
        int n_press = 0, n_long = 0, n_rel = 0, n_rep_win = 0, n_rep = 0;
        int press_e = -1, long_e = -1, rel_e = -1, rep_e1 = -1, rep_e2 = -1;
        btn_in[2] = 1'b1;
        for (int c = 0; c < 130; c++) begin
            if (c == 112) btn_in[2] = 1'b0;
            tick(1);
            if (press_pulse[2]) begin n_press++; if (press_e < 0) press_e = c + 1; end
            if (long_pulse[2]) begin n_long++; if (long_e < 0) long_e = c + 1; end
            if (release_pulse[2]) begin n_rel++; if (rel_e < 0) rel_e = c + 1; end
            if (repeat_pulse[2]) begin
                n_rep++;
                if (c + 1 <= 112) n_rep_win++;
                if (rep_e1 < 0) rep_e1 = c + 1;
                else if (rep_e2 < 0) rep_e2 = c + 1;
            end
        end
        n_cmp++;
        if (n_press !== 1 || press_e !== 12) begin
            n_err++;
            $display("FAIL long_press: got count %0d at %0d expected 1 at 12", n_press, press_e);
        end
        n_cmp++;
        if (n_long !== 1 || long_e !== 62) begin
            n_err++;
            $display("FAIL long_pulse: got count %0d at %0d expected 1 at 62", n_long, long_e);
        end
        n_cmp++;
        if (n_rel !== 1 || rel_e !== 124) begin
            n_err++;
            $display("FAIL long_release: got count %0d at %0d expected 1 at 124", n_rel, rel_e);
        end
`ifdef DEBOUNCE_REPEAT_EN
        n_cmp++;
        if (n_rep_win !== 2 || rep_e1 !== 82 || rep_e2 !== 102) begin
            n_err++;
            $display("FAIL repeat_pulses: got %0d at %0d,%0d expected 2 at 82,102",
                     n_rep_win, rep_e1, rep_e2);
        end
`else
        n_cmp++;
        if (n_rep !== 0) begin
            n_err++;
            $display("FAIL repeat_absent: got %0d expected 0", n_rep);
        end
`endif
        tick(5);
    endtask

    task automatic test_short_press();
        int n_long = 0, n_rel = 0, press_e = -1, rel_e = -1;
        btn_in[3] = 1'b1;
        for (int c = 0; c < 80; c++) begin
            if (c == 42) btn_in[3] = 1'b0;
            tick(1);
            if (press_pulse[3] && press_e < 0) press_e = c + 1;
            if (long_pulse[3]) n_long++;
            if (release_pulse[3]) begin n_rel++; if (rel_e < 0) rel_e = c + 1; end
        end
        n_cmp++;
        if (press_e !== 12) begin
            n_err++;
            $display("FAIL short_press_time: got %0d expected 12", press_e);
        end
        n_cmp++;
        if (n_rel !== 1 || rel_e !== 54) begin
            n_err++;
            $display("FAIL short_release: got count %0d at %0d expected 1 at 54", n_rel, rel_e);
        end
        n_cmp++;
        if (n_long !== 0) begin
            n_err++;
            $display("FAIL short_no_long: got %0d expected 0", n_long);
        end
    endtask

    task automatic test_simultaneous();
        btn_in = 4'b1001;
        tick(12);
        n_cmp++;
        if (press_pulse !== 4'b1001) begin
            n_err++;
            $display("FAIL simul_press: got %b expected 1001", press_pulse);
        end
        tick(1);
        btn_in = 4'b0000;
        tick(12);
        n_cmp++;
        if (release_pulse !== 4'b1001) begin
            n_err++;
            $display("FAIL simul_release: got %b expected 1001", release_pulse);
        end
        tick(5);
    endtask

    task automatic test_reset_mid_hold();
        btn_in[0] = 1'b1;
        tick(40);
        n_cmp++;
        if (btn_level !== 4'b0001) begin
            n_err++;
            $display("FAIL held_before_reset: got %b expected 0001", btn_level);
        end
        rst_n = 1'b0;
        #2;
        n_cmp++;
        if ({btn_level, press_pulse, release_pulse, long_pulse, repeat_pulse} !== 20'h0) begin
            n_err++;
            $display("FAIL async_reset_outputs: got %h expected 0",
                     {btn_level, press_pulse, release_pulse, long_pulse, repeat_pulse});
        end
        tick(3);
        rst_n = 1'b1;
        tick(11);
        n_cmp++;
        if ({btn_level, press_pulse} !== 8'h00) begin
            n_err++;
            $display("FAIL post_reset_early: got %h expected 00", {btn_level, press_pulse});
        end
        tick(1);
        n_cmp++;
        if ({btn_level, press_pulse} !== 8'h11) begin
            n_err++;
            $display("FAIL post_reset_press: got %h expected 11", {btn_level, press_pulse});
        end
        btn_in[0] = 1'b0;
        tick(15);
    endtask

    task automatic test_active_low();
        al_in = 1'b0;
        tick(11);
        n_cmp++;
        if ({al_level, al_press} !== 2'b00) begin
            n_err++;
            $display("FAIL al_early: got %b expected 00", {al_level, al_press});
        end
        tick(1);
        n_cmp++;
        if ({al_level, al_press} !== 2'b11) begin
            n_err++;
            $display("FAIL al_press: got %b expected 11", {al_level, al_press});
        end
        tick(1);
        al_in = 1'b1;
        tick(12);
        n_cmp++;
        if ({al_level, al_release} !== 2'b01) begin
            n_err++;
            $display("FAIL al_release: got %b expected 01", {al_level, al_release});
        end
        tick(3);
    endtask

    initial begin
        test_reset();
        test_clean_press();
        test_bounce();
        test_long_hold();
        test_short_press();
        test_simultaneous();
        test_reset_mid_hold();
        test_active_low();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
